// File: rtl/skew_sync_pkg.sv
// Shared types and helpers for the skewed-synchronizer run controller.
package skew_sync_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A zero length field encodes the full 2^len_w cycle range.
    function automatic int unsigned len_to_cycles(input int unsigned len_val,
                                                  input int unsigned len_w);
        return (len_val == 0) ? (32'd1 << len_w) : len_val;
    endfunction

endpackage

// File: rtl/skew_sync_core.sv
// Skewed synchronizer: buffers lone in0 ones in a saturating counter and
// releases them against lone in1 ones; drain empties the buffer one per cycle.
module skew_sync_core #(
    parameter int unsigned DEP = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           clr,
    input  logic           drain,
    input  logic           in0,
    input  logic           in1,
    output logic           out0,
    output logic [DEP-1:0] occ
);

    localparam logic [DEP-1:0] CNT_FULL = '1;
    localparam logic [DEP-1:0] CNT_ONE  = DEP'(1);

    logic [DEP-1:0] cnt;
    logic [DEP-1:0] cnt_nxt;

    always_comb begin
        out0    = 1'b0;
        cnt_nxt = cnt;
        if (drain) begin
            out0 = 1'b1;
            if (cnt != '0) begin
                cnt_nxt = cnt - CNT_ONE;
            end
        end else if (en) begin
            if (in0 == in1) begin
                out0 = in0;
            end else if (in0) begin
                // Full buffer: the new one bypasses straight to the output.
                if (cnt == CNT_FULL) begin
                    out0 = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end else begin
                if (cnt != '0) begin
                    out0    = 1'b1;
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
        end
        if (clr) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign occ = cnt;

endmodule

// File: rtl/skew_sync_run_ctrl.sv
// Run controller: sequences one bounded run through the skewed synchronizer,
// with start/done handshake, abort and optional drain of buffered ones.
module skew_sync_run_ctrl
    import skew_sync_pkg::*;
#(
    parameter int unsigned DEP      = 2,
    parameter int unsigned LEN_W    = 8,
    parameter bit          DRAIN_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] len,
    input  logic             in0,
    input  logic             in1,
    output logic             out0,
    output logic             out1,
    output logic             out_vld,
    output logic             busy,
    output logic             done,
    output logic [DEP-1:0]   occ
);

    localparam int unsigned REM_W = LEN_W + 1;

    state_t           state;
    logic [REM_W-1:0] remaining;
    logic             core_en;
    logic             core_clr;
    logic             core_drain;
    logic             core_out0;
    logic             run_ends_empty;
    logic             drain_last;

    assign core_en    = (state == RUN);
    assign core_drain = (state == DRAIN);
    assign core_clr   = abort
                      | ((state == IDLE) & start)
                      | ((state == DONE) & !DRAIN_EN);

    skew_sync_core #(
        .DEP(DEP)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (core_en),
        .clr   (core_clr),
        .drain (core_drain),
        .in0   (in0),
        .in1   (in1),
        .out0  (core_out0),
        .occ   (occ)
    );

    // Predicts the post-edge occupancy being zero without exporting the core's next-state.
    assign run_ends_empty = ((occ == '0) && !(in0 && !in1))
                          || ((occ == DEP'(1)) && !in0 && in1);
    assign drain_last     = (occ == DEP'(1)) || (occ == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= RUN;
                        remaining <= REM_W'(len_to_cycles(32'(len), LEN_W));
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    remaining <= remaining - REM_W'(1);
                    if (remaining == REM_W'(1)) begin
                        if (DRAIN_EN && !run_ends_empty) begin
                            state <= DRAIN;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    remaining <= '0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    assign out_vld = (state == RUN) || (state == DRAIN);
    assign out0    = core_out0;
    assign out1    = (state == RUN) & in1;

endmodule

// File: tb/tb_skew_sync_run_ctrl.sv
// Directed bench for skew_sync_run_ctrl (DEP=2, LEN_W=8, DRAIN_EN=1).
module tb_skew_sync_run_ctrl;

    localparam int unsigned DEP   = 2;
    localparam int unsigned LEN_W = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] len   = '0;
    logic             in0   = 1'b0;
    logic             in1   = 1'b0;
    logic             out0, out1, out_vld, busy, done;
    logic [DEP-1:0]   occ;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    skew_sync_run_ctrl #(
        .DEP      (DEP),
        .LEN_W    (LEN_W),
        .DRAIN_EN (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .len     (len),
        .in0     (in0),
        .in1     (in1),
        .out0    (out0),
        .out1    (out1),
        .out_vld (out_vld),
        .busy    (busy),
        .done    (done),
        .occ     (occ)
    );

    // exp packs {out0, out1, out_vld, busy, done, occ[1:0]} for the cycle the inputs are applied.
    typedef struct {
        logic             start;
        logic             abort;
        logic [LEN_W-1:0] len;
        logic             in0;
        logic             in1;
        logic [6:0]       exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic a, input logic [LEN_W-1:0] l,
                                input logic i0, input logic i1,
                                input logic o0, input logic o1, input logic v,
                                input logic b, input logic d, input logic [1:0] oc);
        vec_t x;
        x.start = s;
        x.abort = a;
        x.len   = l;
        x.in0   = i0;
        x.in1   = i1;
        x.exp   = {o0, o1, v, b, d, oc};
        vecs.push_back(x);
    endfunction

    function automatic logic [6:0] obs();
        return {out0, out1, out_vld, busy, done, occ};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic [LEN_W-1:0] l,
                         input logic i0, input logic i1);
        start = s;
        abort = a;
        len   = l;
        in0   = i0;
        in1   = i1;
    endtask

    initial begin
        int seen_done;
        int cyc;
        logic r;

        // T1: saturation at full, then drain of 3 buffered ones (drain ignores in0/in1)
        add(1,0,8'd4,0,0, 0,0,0,0,0,2'd0);
        add(0,0,8'd0,1,0, 0,0,1,1,0,2'd0);
        add(0,0,8'd0,1,0, 0,0,1,1,0,2'd1);
        add(0,0,8'd0,1,0, 0,0,1,1,0,2'd2);
        add(0,0,8'd0,1,0, 1,0,1,1,0,2'd3);
        add(0,0,8'd0,0,1, 1,0,1,1,0,2'd3);
        add(0,0,8'd0,0,1, 1,0,1,1,0,2'd2);
        add(0,0,8'd0,0,1, 1,0,1,1,0,2'd1);
        add(0,0,8'd0,0,0, 0,0,0,1,1,2'd0);
        add(0,0,8'd0,0,0, 0,0,0,0,0,2'd0);
        // abort beats start in IDLE; IDLE ignores stream inputs
        add(1,1,8'd4,1,1, 0,0,0,0,0,2'd0);
        add(0,0,8'd0,1,1, 0,0,0,0,0,2'd0);
        // T2: alternating streams, buffer ends empty, no drain, done at t+5
        add(1,0,8'd4,0,0, 0,0,0,0,0,2'd0);
        add(0,0,8'd0,1,0, 0,0,1,1,0,2'd0);
        add(0,0,8'd0,0,1, 1,1,1,1,0,2'd1);
        add(0,0,8'd0,1,0, 0,0,1,1,0,2'd0);
        add(0,0,8'd0,0,1, 1,1,1,1,0,2'd1);
        add(0,0,8'd0,0,0, 0,0,0,1,1,2'd0);
        add(0,0,8'd0,0,0, 0,0,0,0,0,2'd0);
        // empty-side saturation, len=1
        add(1,0,8'd1,0,0, 0,0,0,0,0,2'd0);
        add(0,0,8'd0,0,1, 0,1,1,1,0,2'd0);
        add(0,0,8'd0,0,0, 0,0,0,1,1,2'd0);
        add(0,0,8'd0,0,0, 0,0,0,0,0,2'd0);
        // T5: start held high; DONE ignores it, IDLE re-accepts (len=1, 1-cycle drain)
        add(1,0,8'd2,0,0, 0,0,0,0,0,2'd0);
        add(1,0,8'd2,1,1, 1,1,1,1,0,2'd0);
        add(1,0,8'd2,1,1, 1,1,1,1,0,2'd0);
        add(1,0,8'd2,0,0, 0,0,0,1,1,2'd0);
        add(1,0,8'd1,0,0, 0,0,0,0,0,2'd0);
        add(0,0,8'd0,1,0, 0,0,1,1,0,2'd0);
        add(0,0,8'd0,0,0, 1,0,1,1,0,2'd1);
        add(0,0,8'd0,0,0, 0,0,0,1,1,2'd0);
        add(0,0,8'd0,0,0, 0,0,0,0,0,2'd0);

        rst_n = 1'b0;
        #2;
        check("reset_outputs", 32'(obs()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].len, vecs[i].in0, vecs[i].in1);
            #1;
            check($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
            step();
        end

        // T3: len=0 means 256 cycles of pass-through
        drive(1, 0, 8'd0, 0, 0);
        step();
        start = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 256; i++) begin
            r   = 1'($urandom_range(0, 1));
            in0 = r;
            in1 = r;
            #1;
            if (done) seen_done++;
            check($sformatf("t3_cyc%0d", i), 32'(obs()), 32'({r, r, 1'b1, 1'b1, 1'b0, 2'd0}));
            step();
        end
        check("t3_no_early_done", 32'(seen_done), 32'd0);
        drive(0, 0, 8'd0, 0, 0);
        #1;
        check("t3_done", 32'(obs()), 32'(7'b000_1100));
        step();

        // T4: abort mid-RUN with occ=2
        drive(1, 0, 8'd10, 0, 0);
        step();
        drive(0, 0, 8'd0, 1, 0);
        step();
        step();
        abort = 1'b1;
        #1;
        check("t4_abort_cycle", 32'(obs()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2}));
        step();
        drive(0, 0, 8'd0, 1, 0);
        #1;
        check("t4_after_abort", 32'(obs()), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 14; i++) begin
            step();
            if (done) seen_done++;
        end
        check("t4_no_done", 32'(seen_done), 32'd0);

        // T6: async reset in the middle of DRAIN
        drive(1, 0, 8'd4, 0, 0);
        step();
        drive(0, 0, 8'd0, 1, 0);
        repeat (4) step();
        #1;
        check("t6_in_drain", 32'(obs()), 32'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3}));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", 32'(obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 8'd0, 0, 0);
        step();
        #1;
        check("t6_idle_after_reset", 32'(obs()), 32'd0);
        drive(1, 0, 8'd1, 0, 0);
        step();
        drive(0, 0, 8'd0, 1, 0);
        #1;
        check("t6_rerun_run", 32'(obs()), 32'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0}));
        step();
        drive(0, 0, 8'd0, 0, 0);
        #1;
        check("t6_rerun_drain", 32'(obs()), 32'({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1}));
        step();
        #1;
        check("t6_rerun_done", 32'(obs()), 32'(7'b000_1100));
        cyc = 0;
        while (busy && cyc < 10) begin
            step();
            cyc++;
        end
        check("t6_back_idle", 32'(obs()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
